// File: rtl/move_btn_conditioner.sv
// move_btn_conditioner: per-button sync, debounce, level and press pulse; AUTO_REPEAT_EN adds held auto-repeat
module move_btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_pulse
);
`ifdef AUTO_REPEAT_EN
    localparam int MAX_A = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C = MAX_A > REPEAT_PERIOD ? MAX_A : REPEAT_PERIOD;
`else
    localparam int MAX_C = DEBOUNCE_CYCLES;
`endif
    localparam int CW = $clog2(MAX_C);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_PRESS, PULSE, HELD, WAIT_RELEASE} state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("move_btn_conditioner: cycle count parameters out of range");
    end

    logic [N_BTN-1:0] pulse_nxt;

    genvar g;
    for (g = 0; g < N_BTN; g++) begin : g_ch
        logic          sync_a, sync_b;
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic          rpt_fire, level_q, pulse_q;

        // two-flop synchroniser for the asynchronous pin
        always_ff @(posedge clk)
            {sync_b, sync_a} <= Reset ? 2'b00 : {sync_a, btn_in[g]};

`ifdef AUTO_REPEAT_EN
        localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
        localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
        logic [CW-1:0] rcnt, rcnt_nxt;
        logic          rep, rep_nxt;

        // repeat timer: runs in HELD, frozen in WAIT_RELEASE, cleared elsewhere
        always_comb begin
            rcnt_nxt = rcnt;
            rep_nxt  = rep;
            rpt_fire = 1'b0;
            if (state == HELD && sync_b) begin
                if (rcnt == (rep ? RP_LAST : RD_LAST)) begin
                    rpt_fire = 1'b1;
                    rcnt_nxt = '0;
                    rep_nxt  = 1'b1;
                end else
                    rcnt_nxt = rcnt + 1'b1;
            end else if (state != HELD && state != WAIT_RELEASE) begin
                rcnt_nxt = '0;
                rep_nxt  = 1'b0;
            end
        end

        // repeat timer registers
        always_ff @(posedge clk) begin
            rcnt <= Reset ? '0 : rcnt_nxt;
            rep  <= Reset ? 1'b0 : rep_nxt;
        end
`else
        assign rpt_fire = 1'b0;
`endif

        // debounce state machine next-state and counter
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                IDLE: if (sync_b) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = '0;
                end
                WAIT_PRESS:
                    if (!sync_b) state_nxt = IDLE;
                    else if (cnt == DB_LAST) state_nxt = PULSE;
                    else cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
                PULSE: begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
                HELD: if (!sync_b) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = '0;
                end
                WAIT_RELEASE:
                    if (sync_b) state_nxt = HELD;
                    else if (cnt == DB_LAST) state_nxt = IDLE;
                    else cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
                default: state_nxt = IDLE;
            endcase
        end

        assign pulse_nxt[g] = (state_nxt == PULSE) || rpt_fire;

        // state, counter and registered level/pulse outputs
        always_ff @(posedge clk) begin
            if (Reset) begin
                state   <= IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                level_q <= state_nxt == PULSE || state_nxt == HELD || state_nxt == WAIT_RELEASE;
                pulse_q <= pulse_nxt[g];
            end
        end

        assign btn_level[g] = level_q;
        assign btn_pulse[g] = pulse_q;
    end

    // combined pulse, aligned with btn_pulse
    always_ff @(posedge clk)
        any_pulse <= Reset ? 1'b0 : |pulse_nxt;
endmodule

// File: tb/tb_move_btn_conditioner.sv
// tb_move_btn_conditioner: random and directed stimulus against a run-length reference model with pulse scoreboard
module tb_move_btn_conditioner;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level, btn_pulse;
    logic         any_pulse;

    always #5 clk = ~clk;

    move_btn_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .Reset(Reset), .btn_in(btn_in),
        .btn_level(btn_level), .btn_pulse(btn_pulse), .any_pulse(any_pulse)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] pulse;
    } exp_t;
    exp_t sb[$];

    // reference model: samples reach the decision logic two edges late;
    // a press is accepted after D+1 consecutive 1 samples, a release after D+1 consecutive 0 samples,
    // the sample taken on the pulse edge is ignored, repeats count held-and-still-1 samples
    logic [N-1:0] h1 = '0, h2 = '0;
    logic [N-1:0] m_lvl = '0, m_pls = '0;
    int ones[N]  = '{default: 0};
    int zeros[N] = '{default: 0};
    int hc[N]    = '{default: 0};
    bit skip[N]  = '{default: 0};
    bit prevz[N] = '{default: 0};

    always @(posedge clk) begin
        cyc++;
        m_pls = '0;
        if (Reset) begin
            h1 = '0;
            h2 = '0;
            m_lvl = '0;
            for (int i = 0; i < N; i++) begin
                ones[i] = 0; zeros[i] = 0; hc[i] = 0; skip[i] = 0; prevz[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!m_lvl[i]) begin
                    ones[i] = h2[i] ? ones[i] + 1 : 0;
                    if (ones[i] == D + 1) begin
                        m_lvl[i] = 1'b1; m_pls[i] = 1'b1; skip[i] = 1;
                        ones[i] = 0; zeros[i] = 0; hc[i] = 0; prevz[i] = 0;
                    end
                end else if (skip[i]) begin
                    skip[i] = 0;
                end else if (h2[i]) begin
                    if (!prevz[i]) begin
                        hc[i]++;
`ifdef AUTO_REPEAT_EN
                        if (hc[i] == RD || (hc[i] > RD && (hc[i] - RD) % RP == 0)) m_pls[i] = 1'b1;
`endif
                    end
                    prevz[i] = 0;
                    zeros[i] = 0;
                end else begin
                    prevz[i] = 1;
                    zeros[i]++;
                    if (zeros[i] == D + 1) begin
                        m_lvl[i] = 1'b0; zeros[i] = 0; hc[i] = 0;
                    end
                end
            end
            h2 = h1;
            h1 = btn_in;
        end
        if (m_pls != '0) sb.push_back('{cyc, m_pls});
    end

    // monitor: per-cycle level/any checks and scoreboard pops on each presented pulse
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (btn_level !== m_lvl) begin
            bad++;
            $display("FAIL level cyc=%0d got=%b exp=%b", cyc, btn_level, m_lvl);
        end
        total++;
        if (any_pulse !== (m_pls != '0)) begin
            bad++;
            $display("FAIL any_pulse cyc=%0d got=%b exp=%b", cyc, any_pulse, m_pls != '0);
        end
        if (any_pulse === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b exp=none", cyc, btn_pulse);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || btn_pulse !== e.pulse) begin
                    bad++;
                    $display("FAIL pulse cyc=%0d got=%b exp=%b@%0d", cyc, btn_pulse, e.pulse, e.cyc);
                end
            end
        end
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missed_pulse cyc=%0d got=none exp=%b@%0d", cyc, e.pulse, e.cyc);
        end
    end

    task automatic drv(input logic [N-1:0] v, input int n);
        btn_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    initial begin
        Reset  = 1'b1;
        btn_in = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", btn_level, 4'b0000);
        chk("reset_pulse", btn_pulse, 4'b0000);
        chk("reset_any", {3'b000, any_pulse}, 4'b0000);
        Reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("t1_pulse_edge6", btn_pulse, 4'b1111);
        @(posedge clk);
        #1;
        chk("t1_pulse_drop", btn_pulse, 4'b0000);
        chk("t1_level_held", btn_level, 4'b1111);
        drv(4'b0000, 12);
        chk("t1_released", btn_level, 4'b0000);

        drv(4'b0001, 3);
        drv(4'b0000, 2);
        drv(4'b0001, 20);
        drv(4'b0000, 2);
        drv(4'b0001, 10);
        chk("t3_level_kept", btn_level, 4'b0001);
        drv(4'b0000, 15);

        drv(4'b0101, 12);
        drv(4'b0000, 15);

        drv(4'b0100, 30);
        drv(4'b0000, 15);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                Reset = 1'b1;
                drv(4'($urandom), $urandom_range(1, 3));
                Reset = 1'b0;
            end
            drv(4'($urandom), $urandom_range(1, 14));
        end
        drv(4'b1010, 40);
        drv(4'b0000, 20);

        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
